// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// ALU operation codes and datapath mux selects.
package mcpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EX_R    = 4'd6,
        S_R_WB    = 4'd7,
        S_EX_I    = 4'd8,
        S_I_WB    = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_JR      = 4'd13,
        S_LUI     = 4'd14
    } state_t;

    typedef enum logic [3:0] {
        C_MEM, C_R, C_JR, C_I, C_BR, C_J, C_JAL, C_LUI, C_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // andi/ori map to AND/OR, whose decoder applies the zero-extended immediate
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;

    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_RA  = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MDR = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;
    localparam logic [1:0] WD_LUI = 2'd3;

    localparam logic [1:0] SB_B    = 2'd0;
    localparam logic [1:0] SB_4    = 2'd1;
    localparam logic [1:0] SB_IMM  = 2'd2;
    localparam logic [1:0] SB_IMM4 = 2'd3;

    localparam logic [1:0] PS_ALU = 2'd0;
    localparam logic [1:0] PS_OUT = 2'd1;
    localparam logic [1:0] PS_JT  = 2'd2;
    localparam logic [1:0] PS_RA  = 2'd3;

endpackage

// File: rtl/mcpu_ctrl_opdec.sv
// Combinational opcode -> instruction-class decode, plus the ALU operation
// used by immediate-form instructions.
module mcpu_ctrl_opdec
    import mcpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [2:0] i_alu_op
);

    always_comb begin
        iclass   = C_ILL;
        i_alu_op = ALU_ADD;
        case (opcode)
            OP_LW, OP_SW:   iclass = C_MEM;
            OP_RTYPE:       iclass = (funct == FN_JR) ? C_JR : C_R;
            OP_ADDI:        iclass = C_I;
            OP_SLTI: begin
                iclass   = C_I;
                i_alu_op = ALU_SLT;
            end
            OP_ANDI: begin
                iclass   = C_I;
                i_alu_op = ALU_AND;
            end
            OP_ORI: begin
                iclass   = C_I;
                i_alu_op = ALU_OR;
            end
            OP_BEQ, OP_BNE: iclass = C_BR;
            OP_J:           iclass = C_J;
            OP_JAL:         iclass = C_JAL;
            OP_LUI:         iclass = C_LUI;
            default:        iclass = C_ILL;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath strobe combinationally from state and inputs.
module mcpu_ctrl
    import mcpu_ctrl_pkg::*;
#(
    parameter int ST_W    = 4,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ior_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic [ST_W-1:0]    state,
    output logic               illegal
);

    state_t     cur;
    logic [5:0] op_q;
    logic [5:0] dec_op;
    iclass_t    iclass;
    logic [2:0] i_alu_op;
    logic [2:0] aop;

    // ID decodes the live IR; later states decode the opcode captured in ID
    assign dec_op = (cur == S_ID) ? opcode : op_q;

    mcpu_ctrl_opdec u_opdec (
        .opcode   (dec_op),
        .funct    (funct),
        .iclass   (iclass),
        .i_alu_op (i_alu_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur  <= S_IF;
            op_q <= '0;
        end else begin
            if (cur == S_ID)
                op_q <= opcode;
            case (cur)
                S_IF:      if (mem_ready) cur <= S_ID;
                S_ID: begin
                    case (iclass)
                        C_MEM:   cur <= S_MEM_ADR;
                        C_R:     cur <= S_EX_R;
                        C_JR:    cur <= S_JR;
                        C_I:     cur <= S_EX_I;
                        C_BR:    cur <= S_BRANCH;
                        C_J:     cur <= S_JUMP;
                        C_JAL:   cur <= S_JAL;
                        C_LUI:   cur <= S_LUI;
                        default: cur <= S_IF;
                    endcase
                end
                S_MEM_ADR: cur <= (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:  if (mem_ready) cur <= S_MEM_WB;
                S_MEM_WR:  if (mem_ready) cur <= S_IF;
                S_EX_R:    cur <= S_R_WB;
                S_EX_I:    cur <= S_I_WB;
                default:   cur <= S_IF;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = RD_RT;
        mem_to_reg    = WD_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SB_B;
        aop           = ALU_ADD;
        pc_source     = PS_ALU;
        illegal       = 1'b0;
        case (cur)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = SB_4;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_ID: begin
                alu_src_b = SB_IMM4;
                illegal   = (iclass == C_ILL);
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = WD_MDR;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
            end
            S_EX_R: begin
                alu_src_a = 1'b1;
                aop       = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = RD_RD;
            end
            S_EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SB_IMM;
                aop       = i_alu_op;
            end
            S_I_WB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                aop           = ALU_SUB;
                pc_source     = PS_OUT;
                pc_write_cond = (op_q == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PS_JT;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PS_JT;
                reg_write  = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = WD_PC;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = PS_RA;
            end
            S_LUI: begin
                reg_write  = 1'b1;
                mem_to_reg = WD_LUI;
            end
            default: ;
        endcase
    end

    assign alu_op = ALUOP_W'(aop);
    assign state  = ST_W'(cur);

endmodule
